// File: rtl/pwm_compare_stage_pkg.sv
// Shared types and constants for the PWM compare stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int PER_W_DEF = 16;

    // Terminal count of the upstream counter and of the period counter
    // at their default widths.
    localparam logic [WIDTH_DEF-1:0] CNT_MAX = '1;
    localparam logic [PER_W_DEF-1:0] PER_MAX = '1;

    // IDLE: no valid previous sample; SYNC: waiting for a clean wrap;
    // RUN: locked to the counter, PWM active.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_compare_stage_if.sv
// Counter-sample inputs and PWM/status outputs of the compare stage.
// Latency: n/a (signal bundle).
// Backpressure: none; counter side is sampled whenever en is high.
interface pwm_compare_stage_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PER_W = PER_W_DEF
);
    logic             en;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] duty_in;
    logic             duty_wr;
    logic             pwm_out;
    logic             wrap_pulse;
    logic             resync_pulse;
    logic [PER_W-1:0] period_cnt;
    logic [WIDTH-1:0] duty_active;

    // Counter / register-write side.
    modport master (
        output en, count, duty_in, duty_wr,
        input  pwm_out, wrap_pulse, resync_pulse, period_cnt, duty_active
    );

    // Compare stage side.
    modport slave (
        input  en, count, duty_in, duty_wr,
        output pwm_out, wrap_pulse, resync_pulse, period_cnt, duty_active
    );
endinterface

// File: rtl/pwm_compare_stage_duty_shadow_reg.sv
// Double-buffered duty register: shadow + pending flag, committed on wrap.
// Latency: duty_active updates on the wrap edge; duty_next shows it combinationally.
// Backpressure: none; a write while pending simply overwrites the shadow.
module duty_shadow_reg
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             duty_wr,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             wrap_ev,
    output logic [WIDTH-1:0] duty_active,
    output logic [WIDTH-1:0] duty_next
);
    logic [WIDTH-1:0] shadow_q;
    logic             pending_q;
    logic [WIDTH-1:0] active_q;

    // Commit the pending shadow on a wrap, then accept any new write; a write
    // on the wrap edge therefore waits for the following wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
            active_q  <= '0;
        end else begin
            if (wrap_ev && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
            if (duty_wr) begin
                shadow_q  <= duty_in;
                pending_q <= 1'b1;
            end
        end
    end

    // Value in effect for a compare made on this edge (new value on a loading wrap).
    always_comb begin
        duty_next = active_q;
        if (wrap_ev && pending_q) begin
            duty_next = shadow_q;
        end
    end

    assign duty_active = active_q;

endmodule

// File: rtl/pwm_compare_stage.sv
// PWM compare against an external up counter with wrap/discontinuity tracking.
// Latency: one clock from count to pwm_out and to the pulses.
// Backpressure: none; en=0 freezes all sampled state and zeroes the pulses.
module pwm_compare_stage
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PER_W = PER_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    pwm_compare_stage_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_TOP = '1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] prev_q;
    logic             step_ok;
    logic             wrap_hit;
    logic             wrap_ev;
    logic             resync_ev;
    logic [WIDTH-1:0] duty_next;
    logic [WIDTH-1:0] duty_active;
    logic             pwm_q;
    logic             wrap_pulse_q;
    logic             resync_pulse_q;
    logic [PER_W-1:0] period_q;

    assign step_ok   = (bus.count == WIDTH'(prev_q + 1'b1));
    assign wrap_hit  = (prev_q == CNT_TOP) && (bus.count == '0);
    assign wrap_ev   = bus.en && (state_q != IDLE) && wrap_hit;
    assign resync_ev = bus.en && (state_q != IDLE) && !step_ok;

    duty_shadow_reg #(
        .WIDTH (WIDTH)
    ) u_duty_shadow_reg (
        .clk         (clk),
        .reset       (reset),
        .duty_wr     (bus.duty_wr),
        .duty_in     (bus.duty_in),
        .wrap_ev     (wrap_ev),
        .duty_active (duty_active),
        .duty_next   (duty_next)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only samples (en=1) move the FSM; a hold is never a jump.
    always_comb begin
        state_d = state_q;
        if (bus.en) begin
            case (state_q)
                IDLE:    state_d = SYNC;
                SYNC:    if (wrap_hit) state_d = RUN;
                RUN:     if (!step_ok) state_d = SYNC;
                default: state_d = IDLE;
            endcase
        end
    end

    // Sample pipeline: previous count, PWM compare, pulses and period count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q         <= '0;
            pwm_q          <= 1'b0;
            wrap_pulse_q   <= 1'b0;
            resync_pulse_q <= 1'b0;
            period_q       <= '0;
        end else if (bus.en) begin
            prev_q         <= bus.count;
            // Compare whenever this sample leaves us in RUN, so the locking wrap
            // already drives count 0; a resync forces the output low.
            pwm_q          <= (state_d == RUN) && (bus.count < duty_next);
            wrap_pulse_q   <= wrap_ev;
            resync_pulse_q <= resync_ev;
            if (wrap_ev && (state_q == RUN)) begin
                period_q <= period_q + 1'b1;
            end
        end else begin
            wrap_pulse_q   <= 1'b0;
            resync_pulse_q <= 1'b0;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.wrap_pulse   = wrap_pulse_q;
    assign bus.resync_pulse = resync_pulse_q;
    assign bus.period_cnt   = period_q;
    assign bus.duty_active  = duty_active;

endmodule

// File: doc/pwm_compare_stage.md
Name: pwm_compare_stage

Overview:
- Downstream consumer of the 8-bit loadable up counter; samples its `count` output and its `en` qualifier.
- Produces a registered PWM waveform from a double-buffered duty register.
- Detects natural rollover (wrap) and discontinuities caused by counter `load`, and keeps a 16-bit count of completed periods.
- Sits between the counter and the pad/driver logic.

Parameters:
- WIDTH, 8, width of `count`, duty and compare path.
- PER_W, 16, width of the completed-period counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- en  input  1  counter enable; `count` is sampled only when 1.
- count  input  WIDTH  current value from the up counter.
- duty_in  input  WIDTH  new duty value.
- duty_wr  input  1  one-cycle strobe; writes `duty_in` into the shadow register.
- pwm_out  output  1  registered PWM output.
- wrap_pulse  output  1  one-cycle pulse on a detected rollover.
- resync_pulse  output  1  one-cycle pulse on a detected count discontinuity.
- period_cnt  output  PER_W  number of completed periods in RUN; wraps at 2^PER_W.
- duty_active  output  WIDTH  duty value currently in effect.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs clear to 0: pwm_out, wrap_pulse, resync_pulse, period_cnt, duty_active.
  - Shadow register clears to 0; pending flag clears; prev_q clears to 0; state goes to IDLE.
- Sample rules:
  - A "sample" is any rising edge with en=1. With en=0: no state, prev_q or period change; pwm_out holds; both pulses are 0.
  - prev_q <= count on every sample.
- Definitions (per sample):
  - wrap: prev_q = 2^WIDTH-1 and count = 0.
  - step_ok: count = prev_q+1 mod 2^WIDTH.
  - resync: state != IDLE and not step_ok.
- State machine:
  - IDLE (no valid prev_q): on the first sample, go to SYNC. pwm_out=0.
  - SYNC (waiting for a clean wrap): on wrap, go to RUN. On any other sample, stay in SYNC. pwm_out=0.
  - RUN: on resync, go to SYNC. On wrap or step_ok, stay in RUN.
- Shadow and pending:
  - duty_wr=1 loads shadow <= duty_in and sets pending. This is independent of en and state.
  - On every wrap in SYNC or RUN: if pending, duty_active <= shadow and pending clears.
  - duty_wr coincident with a wrap: the wrap uses the old shadow. The new value becomes pending for the next wrap.
- PWM:
  - In RUN, on each sample, pwm_out <= (count < duty_active). One clock latency from count.
  - On the wrap sample, the compare uses the duty_active value being loaded on that same edge.
  - duty_active=0 gives a constant low. duty_active=2^WIDTH-1 gives high for 255 of 256 counts.
- Pulses:
  - wrap_pulse=1 for one clock after any sampled wrap in SYNC or RUN.
  - resync_pulse=1 for one clock after a resync; pwm_out <= 0 on that same edge.
- period_cnt:
  - Increments on each wrap while already in RUN. The SYNC->RUN wrap does not count.
  - Wraps silently from 2^PER_W-1 to 0. Holds its value across resync.
- Comparisons are unsigned. A counter hold (en=0) is not a discontinuity.
- Reset mid-operation: returns to IDLE. The first sample after reset release never raises resync_pulse.

Decomposition:
- Shared package `pwm_pkg`:
  - State enum (IDLE, SYNC, RUN).
  - Localparams CNT_MAX = 2^WIDTH-1 and PER_MAX.
- One natural sub-module, `duty_shadow_reg`:
  - Contains the shadow register, pending flag and duty_active.
  - Inputs: clk, reset, duty_wr, duty_in, wrap_ev.
  - Output: duty_active.
- FSM, compare and period counter stay in the top module.

Test Plan:
1. Reset then free-run:
   - Stimulus: reset=0 for 2 clocks, then release; en=1 with count incrementing from 8'hF0; duty_in=8'h40 with a duty_wr pulse before the wrap.
   - Response: wrap_pulse once at 8'hFF->8'h00; state RUN; duty_active=8'h40; pwm_out high for count 0x00-0x3F (one clock delayed), low for 0x40-0xFF; period_cnt=0 then 1 after the next wrap.
2. Load discontinuity:
   - Stimulus: in RUN at count=8'h10, count jumps to 8'hA0.
   - Response: resync_pulse for 1 clock; pwm_out=0 until the next 8'hFF->8'h00; no period_cnt increment at that wrap; increments resume at the following wrap.
3. en hold:
   - Stimulus: en=0 for 5 clocks with count frozen at 8'h20.
   - Response: no pulses; pwm_out and period_cnt unchanged; the resumed step 8'h20->8'h21 is not a resync.
4. Duty update boundaries:
   - Stimulus: duty_wr with 8'h00 on the same edge as a wrap, then duty_wr with 8'hFF mid-period.
   - Response: duty_active unchanged at that wrap; becomes 8'hFF at the next wrap; pwm_out is low for count 0xFF only.
5. Async reset mid-period:
   - Stimulus: reset=0 asserted between clock edges at count=8'h80.
   - Response: all outputs 0 immediately without a clock edge; after release, the first sample gives no resync_pulse; state waits in SYNC until a wrap.
6. period_cnt rollover:
   - Stimulus: force 65536 wraps (or PER_W=4 with 16 wraps).
   - Response: period_cnt returns to 0 without any other side effect.
